// File: rtl/tt_seq_pkg.sv
// Shared definitions for the byte-serial accumulate sequencer: opcodes, FSM
// states, uio pin indices and the status bundle driven onto uio_out[7:4].
package tt_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_READ = 2'd3
  } op_t;

  // ST_SETTLE is the one cycle in which the output byte register picks up the
  // finished accumulator before out_valid is raised.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam int UIO_IN_VALID  = 0;
  localparam int UIO_OP_LSB    = 1;
  localparam int UIO_OP_MSB    = 2;
  localparam int UIO_OUT_ACK   = 3;
  localparam int UIO_IN_READY  = 4;
  localparam int UIO_BUSY      = 5;
  localparam int UIO_CARRY     = 6;
  localparam int UIO_OUT_VALID = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  // Field order matches uio_out[7:4].
  typedef struct packed {
    logic out_valid;
    logic carry;
    logic busy;
    logic in_ready;
  } status_t;

  // Width of the slice index / byte select; at least one bit so a single-slice
  // build still has a legal vector.
  function automatic int sel_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/tt_byte_adder.sv
// The single shared 8-bit adder slice: sum = a + b + cin, with carry out.
module tt_byte_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {8'h00, cin};
  assign sum  = full[7:0];
  assign cout = full[8];

endmodule

// File: rtl/tt_add_sequencer.sv
// Tiny Tapeout tile that runs ACC_W-bit add/sub on an accumulator one byte per
// cycle through a shared 8-bit adder, with valid/ready in and valid/ack out.
//
// Handshake: an operand is taken on a rising edge where ena & in_valid &
// in_ready; a result is retired on a rising edge where ena & out_valid &
// out_ack. in_ready, busy and out_valid are pure decodes of the state.
module tt_add_sequencer
  import tt_seq_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int NB    = ACC_W / 8;
  localparam int IDX_W = sel_width(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  state_t           state_q;
  state_t           state_d;
  op_t              op_q;
  op_t              op_in;
  logic [7:0]       data_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] sel_in;
  logic [7:0]       acc_q [NB];
  logic             chain_q;
  logic             carry_q;
  logic [7:0]       uo_q;
  status_t          status;

  logic             in_valid;
  logic             out_ack;
  logic             accept;
  logic             last_slice;
  logic [7:0]       slice_a;
  logic [7:0]       slice_b;
  logic [7:0]       slice_sum;
  logic             slice_cout;
  logic [7:0]       sel_byte;
  logic             unused_pins;

  assign in_valid    = uio_in[UIO_IN_VALID];
  assign out_ack     = uio_in[UIO_OUT_ACK];
  assign op_in       = op_t'(uio_in[UIO_OP_MSB:UIO_OP_LSB]);
  assign unused_pins = ^uio_in[7:4];

  assign accept     = ena && in_valid && (state_q == ST_IDLE);
  assign last_slice = (idx_q == LAST_IDX);

  generate
    if (NB > 1) begin : g_sel_multi
      assign sel_in = ui_in[IDX_W-1:0];
    end else begin : g_sel_single
      assign sel_in = '0;
    end
  endgenerate

  // Only slice 0 sees the operand byte; higher slices add 0 (or 0xFF for SUB,
  // since the whole operand is inverted and c_0 supplies the +1).
  assign slice_a = acc_q[idx_q];
  assign slice_b = ((idx_q == '0) ? data_q : 8'h00) ^ {8{op_q == OP_SUB}};

  tt_byte_adder u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (chain_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (sel_q == IDX_W'(i)) sel_byte = acc_q[i];
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (op_in == OP_ADD || op_in == OP_SUB) state_d = ST_EXEC;
            else                                    state_d = ST_SETTLE;
          end
        end
        ST_EXEC:   if (last_slice) state_d = ST_SETTLE;
        ST_SETTLE: state_d = ST_RESULT;
        ST_RESULT: if (out_ack) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    status           = '0;
    status.in_ready  = (state_q == ST_IDLE);
    status.busy      = (state_q == ST_EXEC) || (state_q == ST_SETTLE);
    status.out_valid = (state_q == ST_RESULT);
    status.carry     = carry_q;
  end

  assign uio_out = {status, 4'b0000};
  assign uio_oe  = UIO_OE_MASK;
  assign uo_out  = uo_q;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_LOAD;
      data_q  <= 8'h00;
      idx_q   <= '0;
      sel_q   <= '0;
      chain_q <= 1'b0;
      carry_q <= 1'b0;
      uo_q    <= 8'h00;
      for (int i = 0; i < NB; i++) acc_q[i] <= 8'h00;
    end else if (ena) begin
      // Tracks acc/sel every cycle; acc and sel are final by ST_SETTLE and
      // frozen through ST_RESULT, so uo_out is stable while out_valid is high.
      uo_q <= sel_byte;

      if (accept) begin
        op_q    <= op_in;
        data_q  <= ui_in;
        idx_q   <= '0;
        chain_q <= (op_in == OP_SUB);
        case (op_in)
          OP_LOAD: begin
            acc_q[0] <= ui_in;
            for (int i = 1; i < NB; i++) acc_q[i] <= 8'h00;
            sel_q <= '0;
          end
          OP_READ: sel_q <= sel_in;
          default: sel_q <= '0;
        endcase
      end

      if (state_q == ST_EXEC) begin
        acc_q[idx_q] <= slice_sum;
        chain_q      <= slice_cout;
        idx_q        <= idx_q + 1'b1;
        if (last_slice) carry_q <= slice_cout;
      end
    end
  end

endmodule
